// File: rtl/msrv32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_pkg
//  Description : Shared constants and types for the instruction-fetch path.
//  Revision    : 1.0 - initial release
// ============================================================================
package msrv32_pkg;

  localparam logic [1:0] c_FETCH_IDLE = 2'd0;
  localparam logic [1:0] c_FETCH_REQ  = 2'd1;
  localparam logic [1:0] c_FETCH_WAIT = 2'd2;
  localparam logic [1:0] c_FETCH_HOLD = 2'd3;

  // ADDI x0,x0,0
  localparam logic [31:0] c_NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] c_BOOT_ADDRESS = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic is_word_aligned(input logic [1:0] pc_lsb);
    return (pc_lsb == 2'b00);
  endfunction

endpackage : msrv32_pkg
`default_nettype wire

// File: rtl/msrv32_fetch_hold_reg.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_fetch_hold_reg
//  Description : Output register presenting instruction/PC/valid to decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_fetch_hold_reg
  import msrv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR    = c_NOP_INSTR,
  parameter logic [31:0] BOOT_ADDRESS = c_BOOT_ADDRESS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_clear_valid,
  input  fetch_word_t i_data,
  output fetch_word_t o_data,
  output logic        o_valid
);

  fetch_word_t r_data;
  logic        r_valid;

  // Flush beats load: a redirected or discarded response must never surface.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data.instr <= NOP_INSTR;
      r_data.pc    <= BOOT_ADDRESS;
      r_valid      <= 1'b0;
    end else if (i_flush) begin
      r_data.instr <= NOP_INSTR;
      r_valid      <= 1'b0;
    end else if (i_load) begin
      r_data       <= i_data;
      r_valid      <= 1'b1;
    end else if (i_clear_valid) begin
      r_valid      <= 1'b0;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule : msrv32_fetch_hold_reg
`default_nettype wire

// File: rtl/msrv32_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : msrv32_imem_fetch_ctrl
//  Description : Single-outstanding instruction fetch controller (valid/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module msrv32_imem_fetch_ctrl
  import msrv32_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDRESS = c_BOOT_ADDRESS,
  parameter logic [31:0] NOP_INSTR    = c_NOP_INSTR
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] pc_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [31:0] imaddr_out,
  output logic        imaddr_valid_out,
  input  logic        imaddr_ready_in,
  input  logic [31:0] instr_in,
  input  logic        instr_valid_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_fetched_out,
  output logic        instr_valid_out,
  output logic        pc_advance_out,
  output logic        misaligned_out
);

  logic [1:0]  r_state;
  logic        r_discard;
  logic [31:0] r_imaddr;
  logic        r_imaddr_valid;
  logic        r_pc_advance;
  logic        r_misaligned;

  logic        w_resp;
  logic        w_drop_resp;
  logic        w_load;
  logic        w_flush_nop;
  fetch_word_t w_resp_word;
  fetch_word_t w_hold_word;

  always_comb begin
    w_resp      = (r_state == c_FETCH_WAIT) && instr_valid_in;
    w_drop_resp = w_resp && (r_discard || flush_in);
    w_load      = w_resp && !w_drop_resp;
    w_flush_nop = w_drop_resp || ((r_state == c_FETCH_HOLD) && flush_in);
    w_resp_word.instr = instr_in;
    w_resp_word.pc    = r_imaddr;
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state        <= c_FETCH_IDLE;
      r_discard      <= 1'b0;
      r_imaddr       <= BOOT_ADDRESS;
      r_imaddr_valid <= 1'b0;
      r_pc_advance   <= 1'b0;
      r_misaligned   <= 1'b0;
    end else begin
      r_pc_advance <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        c_FETCH_IDLE: begin
          if (!stall_in) begin
            if (is_word_aligned(pc_in[1:0])) begin
              r_imaddr       <= pc_in;
              r_imaddr_valid <= 1'b1;
              r_state        <= c_FETCH_REQ;
            end else begin
              r_misaligned   <= 1'b1;
            end
          end
        end
        // Request stays up until accepted even on flush; the response is
        // consumed later and dropped via the discard flag.
        c_FETCH_REQ: begin
          if (flush_in) begin
            r_discard <= 1'b1;
          end
          if (imaddr_ready_in) begin
            r_imaddr_valid <= 1'b0;
            r_state        <= c_FETCH_WAIT;
          end
        end
        c_FETCH_WAIT: begin
          if (instr_valid_in) begin
            if (r_discard || flush_in) begin
              r_discard <= 1'b0;
              r_state   <= c_FETCH_IDLE;
            end else if (!stall_in) begin
              r_pc_advance <= 1'b1;
              r_state      <= c_FETCH_IDLE;
            end else begin
              r_state      <= c_FETCH_HOLD;
            end
          end else if (flush_in) begin
            r_discard <= 1'b1;
          end
        end
        c_FETCH_HOLD: begin
          if (flush_in) begin
            r_state <= c_FETCH_IDLE;
          end else if (!stall_in) begin
            r_pc_advance <= 1'b1;
            r_state      <= c_FETCH_IDLE;
          end
        end
        default: begin
          r_state <= c_FETCH_IDLE;
        end
      endcase
    end
  end

  msrv32_fetch_hold_reg #(
    .NOP_INSTR    (NOP_INSTR),
    .BOOT_ADDRESS (BOOT_ADDRESS)
  ) u_hold_reg (
    .clk           (ms_riscv32_mp_clk_in),
    .rst           (ms_riscv32_mp_rst_in),
    .i_load        (w_load),
    .i_flush       (w_flush_nop),
    .i_clear_valid (r_pc_advance),
    .i_data        (w_resp_word),
    .o_data        (w_hold_word),
    .o_valid       (instr_valid_out)
  );

  assign imaddr_out       = r_imaddr;
  assign imaddr_valid_out = r_imaddr_valid;
  assign pc_advance_out   = r_pc_advance;
  assign misaligned_out   = r_misaligned;
  assign instr_out        = w_hold_word.instr;
  assign pc_fetched_out   = w_hold_word.pc;

endmodule : msrv32_imem_fetch_ctrl
`default_nettype wire

// File: tb/tb_msrv32_imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msrv32_imem_fetch_ctrl
//  Description : Scoreboard bench for the instruction-fetch controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msrv32_imem_fetch_ctrl;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        stall_in;
  logic        flush_in;
  logic [31:0] imaddr_out;
  logic        imaddr_valid_out;
  logic        imaddr_ready_in;
  logic [31:0] instr_in;
  logic        instr_valid_in;
  logic [31:0] instr_out;
  logic [31:0] pc_fetched_out;
  logic        instr_valid_out;
  logic        pc_advance_out;
  logic        misaligned_out;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          resp_delay = 1;
  logic [31:0] resp_word = 32'h0;

  always #5 clk = ~clk;

  msrv32_imem_fetch_ctrl dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .pc_in                (pc_in),
    .stall_in             (stall_in),
    .flush_in             (flush_in),
    .imaddr_out           (imaddr_out),
    .imaddr_valid_out     (imaddr_valid_out),
    .imaddr_ready_in      (imaddr_ready_in),
    .instr_in             (instr_in),
    .instr_valid_in       (instr_valid_in),
    .instr_out            (instr_out),
    .pc_fetched_out       (pc_fetched_out),
    .instr_valid_out      (instr_valid_out),
    .pc_advance_out       (pc_advance_out),
    .misaligned_out       (misaligned_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, expected %08h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    exp_t e;
    e.instr = instr;
    e.pc    = pc;
    sb_q.push_back(e);
  endtask

  task automatic wait_adv(input int limit, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (pc_advance_out === 1'b1 || n >= limit) break;
    end
    check("adv_seen", 32'(pc_advance_out), 32'd1);
  endtask

  // Memory model: one response, resp_delay cycles after each acceptance.
  initial begin : mem_model
    instr_valid_in = 1'b0;
    instr_in       = 32'h0;
    forever begin
      @(negedge clk);
      if (imaddr_valid_out && imaddr_ready_in && !rst) begin
        n_acc++;
        @(posedge clk);
        repeat (resp_delay - 1) @(posedge clk);
        #1;
        instr_valid_in = 1'b1;
        instr_in       = resp_word;
        @(posedge clk);
        #1;
        instr_valid_in = 1'b0;
        instr_in       = 32'h0;
      end
    end
  end

  // Every advance pulse must match the oldest expected presentation.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (pc_advance_out === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("adv_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("instr_out", instr_out, e.instr);
          check("pc_fetched", pc_fetched_out, e.pc);
          check("valid_at_adv", 32'(instr_valid_out), 32'd1);
        end
      end
    end
  end

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int acc0;
    rst = 1'b1; pc_in = 32'h40; stall_in = 1'b0; flush_in = 1'b0; imaddr_ready_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_imaddr", imaddr_out, 32'h0);
    check("rst_imvalid", 32'(imaddr_valid_out), 32'd0);
    check("rst_instr", instr_out, c_NOP);
    check("rst_pcf", pc_fetched_out, 32'h0);
    check("rst_ivalid", 32'(instr_valid_out), 32'd0);
    check("rst_adv", 32'(pc_advance_out), 32'd0);
    check("rst_mis", 32'(misaligned_out), 32'd0);

    // basic fetch
    resp_word = 32'h0050_0093; resp_delay = 1;
    push(32'h0050_0093, 32'h40);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("req_valid", 32'(imaddr_valid_out), 32'd1);
    check("req_addr", imaddr_out, 32'h40);
    wait_adv(8, n);
    check("basic_latency", 32'(n), 32'd2);
    stall_in = 1'b1;
    @(negedge clk);
    check("adv_one_cycle", 32'(pc_advance_out), 32'd0);
    check("valid_drop", 32'(instr_valid_out), 32'd0);
    check("idle_imvalid", 32'(imaddr_valid_out), 32'd0);

    // backpressure: address held while ready is low
    @(posedge clk); #1;
    imaddr_ready_in = 1'b0; pc_in = 32'h44; resp_word = 32'h00a0_0113;
    push(32'h00a0_0113, 32'h44); stall_in = 1'b0;
    acc0 = n_acc;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_valid", 32'(imaddr_valid_out), 32'd1);
      check("bp_addr", imaddr_out, 32'h44);
      if (i == 0) pc_in = 32'h80;
    end
    @(posedge clk); #1 imaddr_ready_in = 1'b1;
    wait_adv(8, n);
    stall_in = 1'b1;
    check("bp_latency", 32'(n), 32'd3);
    check("bp_accepts", 32'(n_acc - acc0), 32'd1);

    // stall from the response cycle for three cycles
    @(negedge clk);
    pc_in = 32'h48; resp_word = 32'h0030_8193; push(32'h0030_8193, 32'h48); stall_in = 1'b0;
    @(negedge clk);
    stall_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_noadv", 32'(pc_advance_out), 32'd0);
      if (i >= 1) begin
        check("stall_valid", 32'(instr_valid_out), 32'd1);
        check("stall_instr", instr_out, 32'h0030_8193);
      end
    end
    stall_in = 1'b0;
    @(negedge clk);
    check("stall_release_adv", 32'(pc_advance_out), 32'd1);
    stall_in = 1'b1;
    @(negedge clk);
    check("stall_valid_drop", 32'(instr_valid_out), 32'd0);

    // misaligned PC
    @(negedge clk);
    pc_in = 32'h42; stall_in = 1'b0;
    @(negedge clk);
    check("mis_pulse", 32'(misaligned_out), 32'd1);
    check("mis_noreq", 32'(imaddr_valid_out), 32'd0);
    stall_in = 1'b1;
    @(negedge clk);
    check("mis_one_cycle", 32'(misaligned_out), 32'd0);
    check("mis_noreq2", 32'(imaddr_valid_out), 32'd0);

    // flush while waiting for the response
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    resp_word = 32'hDEAD_BEEF; resp_delay = 2;
    @(negedge clk);
    pc_in = 32'h4C; stall_in = 1'b0;
    @(negedge clk);
    check("fl_req", 32'(imaddr_valid_out), 32'd1);
    @(negedge clk);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0; stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("fl_valid", 32'(instr_valid_out), 32'd0);
      check("fl_instr", instr_out, c_NOP);
    end

    // discard flag must be clear: the next fetch is presented
    resp_delay = 1; resp_word = 32'h0000_0297; push(32'h0000_0297, 32'h50);
    pc_in = 32'h50; stall_in = 1'b0;
    wait_adv(8, n);
    stall_in = 1'b1;
    check("post_flush_latency", 32'(n), 32'd3);

    // flush while holding a stalled instruction
    @(negedge clk);
    pc_in = 32'h54; resp_word = 32'h1111_1111; stall_in = 1'b0;
    @(negedge clk);
    stall_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("hold_valid", 32'(instr_valid_out), 32'd1);
    flush_in = 1'b1;
    @(negedge clk);
    flush_in = 1'b0;
    check("hold_fl_valid", 32'(instr_valid_out), 32'd0);
    check("hold_fl_instr", instr_out, c_NOP);
    repeat (3) @(negedge clk);
    check("hold_fl_idle", 32'(instr_valid_out), 32'd0);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_msrv32_imem_fetch_ctrl
`default_nettype wire

// File: doc/msrv32_imem_fetch_ctrl.md
Name: msrv32_imem_fetch_ctrl

Overview:
Instruction-fetch controller on the consumer side of the PC register (msrv32_reg_block_1). It takes the registered PC and issues one instruction-memory request at a time using a valid/ready handshake. It captures the returned instruction and presents it to decode with the matching PC. It also tells the PC mux when the PC may advance, and handles stall, flush and misaligned PC.

Parameters:
BOOT_ADDRESS, 32'h0000_0000, imem address driven while in reset
NOP_INSTR, 32'h0000_0013, instruction presented when nothing is valid (ADDI x0,x0,0)

Ports:
ms_riscv32_mp_clk_in  input  1  single clock; all logic on rising edge
ms_riscv32_mp_rst_in  input  1  synchronous, active-high reset
pc_in  input  32  current PC from msrv32_reg_block_1 (pc_out)
stall_in  input  1  decode not ready; hold the presented instruction
flush_in  input  1  branch/trap redirect; discard the in-flight fetch
imaddr_out  output  32  instruction memory address
imaddr_valid_out  output  1  request valid
imaddr_ready_in  input  1  memory accepts the request
instr_in  input  32  returned instruction word
instr_valid_in  input  1  response valid (one cycle, exactly one per accepted request)
instr_out  output  32  instruction to decode
pc_fetched_out  output  32  PC of instr_out
instr_valid_out  output  1  instr_out is valid
pc_advance_out  output  1  one-cycle pulse; PC mux may load the next PC
misaligned_out  output  1  one-cycle pulse; pc_in[1:0] != 0 at issue

Behaviour:
- Reset (synchronous, wins over all inputs):
  - state=IDLE; imaddr_out=BOOT_ADDRESS; imaddr_valid_out=0.
  - instr_out=NOP_INSTR; pc_fetched_out=BOOT_ADDRESS.
  - instr_valid_out=0, pc_advance_out=0, misaligned_out=0; discard flag=0.
- FSM states: IDLE, REQ, WAIT, HOLD. Only one request may be outstanding.
- IDLE, with stall_in=0:
  - pc_in[1:0]==0: register imaddr_out<=pc_in, imaddr_valid_out<=1, go to REQ.
  - otherwise: misaligned_out<=1 for one cycle, no request issued, stay in IDLE.
- IDLE, with stall_in=1: remain idle.
- REQ:
  - imaddr_valid_out and imaddr_out stay stable until imaddr_ready_in=1. Valid never drops before acceptance, even on flush.
  - On acceptance: imaddr_valid_out<=0, go to WAIT.
- WAIT, on instr_valid_in=1:
  - discard flag set: clear it, keep instr_valid_out=0 and instr_out=NOP_INSTR, go to IDLE.
  - otherwise: instr_out<=instr_in, pc_fetched_out<=imaddr_out, instr_valid_out<=1.
  - If stall_in=0 in the same cycle: pc_advance_out<=1, go to IDLE. Else go to HOLD.
- HOLD:
  - instr_out, pc_fetched_out and instr_valid_out are held.
  - When stall_in=0: pc_advance_out<=1 for one cycle, go to IDLE.
- instr_valid_out drops to 0 in the cycle after the advance pulse, unless a new response lands in that cycle.
- flush_in:
  - In REQ or WAIT: set the discard flag. The response is still consumed but never presented.
  - In HOLD: drop instr_valid_out to 0, instr_out<=NOP_INSTR, go to IDLE, no advance pulse.
  - In IDLE: no effect.
  - flush_in has priority over stall_in.
- Latency (ready=1, response one cycle after acceptance, no stall):
  - Cycle 0: IDLE samples pc_in.
  - Cycle 1: request visible and accepted.
  - Cycle 2: response.
  - Cycle 3: instr_out and pc_advance_out visible.
  - Back-to-back fetch period is 3 cycles.
- Error cases:
  - instr_valid_in outside WAIT is ignored.
  - Reset while in WAIT abandons the outstanding response, and the memory must tolerate this. A later stray instr_valid_in is ignored because state is IDLE.
- Arithmetic: none; PC values are passed through unmodified.

Decomposition:
- Shared package msrv32_pkg:
  - fetch FSM state encoding: IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3
  - NOP_INSTR constant
  - BOOT_ADDRESS default
- One natural sub-module: msrv32_fetch_hold_reg, holding the instr/PC/valid output register with load, hold and flush-to-NOP control.
- The FSM stays in the top module.

Test Plan:
- Reset with rst=1 for 2 cycles, pc_in=32'h0000_0040 -> imaddr_out=32'h0, imaddr_valid_out=0, instr_out=32'h0000_0013, instr_valid_out=0.
- Basic fetch: pc_in=32'h0000_0040, ready=1, response 32'h00500093 one cycle after acceptance -> cycle 3: instr_out=32'h00500093, pc_fetched_out=32'h40, instr_valid_out=1, pc_advance_out=1 for exactly one cycle.
- Backpressure: ready=0 for 4 cycles -> imaddr_valid_out=1 and imaddr_out=32'h40 stable all 4 cycles; one request accepted when ready rises.
- Stall: stall_in=1 from the response cycle for 3 cycles -> instr_out held, instr_valid_out=1, no pc_advance_out; advance pulse in the cycle stall_in falls.
- Flush: flush_in pulsed in WAIT before response 32'hDEADBEEF -> instr_valid_out stays 0, instr_out stays 32'h0000_0013, no advance pulse, FSM returns to IDLE.
- Misaligned: pc_in=32'h0000_0042 -> misaligned_out=1 for one cycle, imaddr_valid_out stays 0.
